divider_8bit_seq: RTL and testbench
===================================

# divider_8bit_seq

Sequential unsigned integer divider. It is the inverse companion of the combinational 8-bit multiplier in the ALU datapath. It computes QUOTIENT = DATA1 / DATA2 and REMAINDER = DATA1 % DATA2 using the restoring shift-subtract method, one quotient bit per clock. A START/BUSY/DONE handshake lets the CPU control unit stall on a divide instruction until the result is valid.

## Interface
- WIDTH, 8, operand/result width in bits; all widths below derive from it.
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- START  input  1  request; sampled on a rising edge only while in IDLE.
- DATA1  input  WIDTH  dividend, unsigned.
- DATA2  input  WIDTH  divisor, unsigned.
- QUOTIENT  output  WIDTH  registered quotient of the last completed operation.
- REMAINDER  output  WIDTH  registered remainder of the last completed operation.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; results valid and updated in this cycle.
- DIV_BY_ZERO  output  1  registered; set with DONE when the latched DATA2 was 0.

## Operation
- States: IDLE and RUN.
- Internal registers:
  - rem: WIDTH+1 bits, partial remainder.
  - dvd: WIDTH bits, shifting dividend / quotient.
  - dsr: WIDTH bits, latched divisor.
  - cnt: iteration counter, clog2(WIDTH)+1 bits.
- IDLE, START=1 at an edge:
  - latch dvd←DATA1, dsr←DATA2, rem←0, cnt←0.
  - latch dbz←(DATA2==0).
  - go to RUN; BUSY←1.
- IDLE, START=0: hold all state.
- RUN, each edge performs one iteration:
  - t = {rem[WIDTH-1:0], dvd[WIDTH-1]} − {1'b0, dsr}, computed WIDTH+1 bits wide.
  - if t is non-negative (MSB=0): rem←t, dvd←{dvd[WIDTH-2:0],1}.
  - otherwise: rem←{rem[WIDTH-1:0], dvd[WIDTH-1]}, dvd←{dvd[WIDTH-2:0],0}.
  - cnt←cnt+1.
- RUN, iteration with cnt==WIDTH−1 (the last one):
  - QUOTIENT←final dvd, REMAINDER←final rem[WIDTH-1:0], DIV_BY_ZERO←dbz.
  - DONE←1, BUSY←0, go to IDLE.
- START while in RUN is ignored and not queued.
- DATA1/DATA2 changes after the accepting edge have no effect.
- Divide by zero uses the same fixed latency with no special path. The algorithm yields QUOTIENT = all ones and REMAINDER = DATA1, and DIV_BY_ZERO=1.
- QUOTIENT, REMAINDER and DIV_BY_ZERO hold their values until the next DONE. They do not change during RUN.
- Results are always exact: rem never exceeds WIDTH+1 bits, and there is no overflow case for unsigned division.

## Timing
- Reset (RESET=0, asynchronous, immediate):
  - state=IDLE.
  - BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0.
  - rem, dvd, dsr and cnt are cleared.
- Reset is released synchronously to CLK by the system. The first edge with RESET=1 may accept START.
- Let E0 be the edge at which START is accepted:
  - after E0: BUSY=1.
  - edges E1..E8 (WIDTH=8) perform the iterations.
  - after E8: BUSY=0, DONE=1, outputs updated.
  - after E9: DONE=0.
- Latency is WIDTH cycles from the accepting edge to DONE visible. Throughput is one operation per WIDTH+1 cycles maximum.
- Back-to-back operation: the DONE cycle is IDLE. START=1 at E9 is accepted, DONE drops and BUSY rises after E9.
- DONE and BUSY are never high together.
- Reset asserted mid-RUN:
  - the operation is aborted and no DONE is produced.
  - outputs return to their reset values, including the previously held results.

## Test plan
- DATA1=200, DATA2=7, START pulse → after 8 cycles DONE=1 for one cycle, QUOTIENT=28, REMAINDER=4, DIV_BY_ZERO=0; BUSY high exactly 8 cycles.
- 255/1 → QUOTIENT=255, REMAINDER=0. 3/10 → QUOTIENT=0, REMAINDER=3. 0/9 → QUOTIENT=0, REMAINDER=0.
- 5/0 → DONE after 8 cycles, QUOTIENT=8'hFF, REMAINDER=5, DIV_BY_ZERO=1. A following 12/4 clears DIV_BY_ZERO and gives QUOTIENT=3, REMAINDER=0.
- START held high continuously with 100/9, then 100/10 presented on the DONE cycle:
  - the first DONE gives QUOTIENT=11, REMAINDER=1.
  - the second operation starts at E9 and its DONE gives QUOTIENT=10, REMAINDER=0.
  - DONE pulses are spaced 9 cycles apart.
  - operands changed during RUN, plus extra START pulses there, have no effect.
- Assert RESET=0 at cycle 4 of a 77/3 operation:
  - all outputs go to 0 immediately and no DONE follows.
  - after release, 77/3 gives QUOTIENT=25, REMAINDER=2.
- Randomized 1000 operand pairs, including DATA2=0, compared against a reference model: QUOTIENT×DATA2+REMAINDER=DATA1 and REMAINDER<DATA2 whenever DATA2≠0.

Source files
------------

// File: rtl/divider_8bit_seq.sv
// -----------------------------------------------------------------------------
// divider_8bit_seq
//
// Sequential unsigned divider (restoring shift-subtract). It produces one
// quotient bit per clock and uses a START/BUSY/DONE handshake, so a control
// unit can stall on a divide until the result is valid.
//
// Ports
//   i_clk          clock; all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        request; accepted only on an edge while idle
//   i_data1        dividend (unsigned, WIDTH bits)
//   i_data2        divisor  (unsigned, WIDTH bits)
//   o_quotient     quotient of the last completed operation (registered)
//   o_remainder    remainder of the last completed operation (registered)
//   o_busy         high while an operation is in progress
//   o_done         one-cycle pulse when the results are updated
//   o_div_by_zero  set together with o_done when the latched divisor was 0
//
// Timing: the edge that accepts START is E0. Edges E1..E(WIDTH) each run one
// iteration, and o_done is visible after E(WIDTH). The DONE cycle is idle, so
// a new START can be accepted on the very next edge.
// -----------------------------------------------------------------------------
module divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  // The stored partial remainder is always smaller than the divisor, so it
  // fits in WIDTH bits; the extra bit only exists inside the trial subtract.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dsr;   // latched divisor
  logic [CNT_W-1:0] r_cnt;   // iteration counter
  logic             r_dbz;   // latched divisor==0 flag

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor, WIDTH+1 bits wide so the MSB
  // of the trial acts as the borrow (1 = negative, restore).
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_neg;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;

  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dsr};
  assign w_neg      = w_trial[WIDTH];
  assign w_rem_next = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_dvd_next = {r_dvd[WIDTH-2:0], ~w_neg};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dsr         <= '0;
      r_cnt         <= '0;
      r_dbz         <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // DONE is a single-cycle pulse; it always drops on the next edge,
          // including the edge that accepts a back-to-back START.
          r_done <= 1'b0;
          if (i_start) begin
            r_dvd   <= i_data1;
            r_dsr   <= i_data2;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dbz   <= (i_data2 == '0);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // START is ignored here; operands were already latched.
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_quotient    <= w_dvd_next;
            r_remainder   <= w_rem_next;
            r_div_by_zero <= r_dbz;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_8bit_seq.sv
module tb_divider_8bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  int vectors;
  int miscompares;

  divider_8bit_seq #(.WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_data1       (data1),
    .i_data2       (data2),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the DONE pulse; n = number of falling edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One complete operation checked against plain arithmetic. With junk set,
  // operands and START are scrambled while the divider is running.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit junk);
    logic [7:0] q0, r0, eq, er;
    int lat, bcnt;
    bit held, overlap;
    eq = (b == 0) ? 8'hFF : a / b;
    er = (b == 0) ? a : a % b;
    @(negedge clk);
    data1 = a; data2 = b; start = 1'b1;
    q0 = quotient; r0 = remainder;
    @(negedge clk);          // E0 has accepted the request
    start = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1; overlap = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      if (quotient !== q0 || remainder !== r0) held = 1'b0;
      if (junk) begin
        data1 = 8'($urandom);
        data2 = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end
    start = 1'b0;
    chk("latency", lat, 8);
    chk("busy_cycles", bcnt, 8);
    chk("held_in_run", held, 1);
    chk("busy_done_overlap", overlap, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", dbz, (b == 0) ? 1 : 0);
    if (b != 0) begin
      chk("identity", quotient * b + remainder, a);
      chk("rem_lt_dsr", (remainder < b) ? 1 : 0, 1);
    end
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, dbz, lat);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int n1, n2;
    bit saw_done;
    logic [7:0] ra, rb;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b0; data1 = '0; data2 = '0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'd200, 8'd7, 1'b0);
    do_op(8'd255, 8'd1, 1'b0);
    do_op(8'd3, 8'd10, 1'b0);
    do_op(8'd0, 8'd9, 1'b0);
    do_op(8'd5, 8'd0, 1'b0);
    do_op(8'd12, 8'd4, 1'b1);

    // Back-to-back with START held high throughout
    @(negedge clk);
    data1 = 8'd100; data2 = 8'd9; start = 1'b1;
    @(negedge clk);
    data1 = 8'd1; data2 = 8'd1;       // changed during RUN: no effect
    wait_done(n1);
    chk("b2b_lat1", n1, 8);
    chk("b2b_q1", quotient, 11);
    chk("b2b_r1", remainder, 1);
    $display("b2b op1 100 / 9 -> q=%0d r=%0d", quotient, remainder);
    data1 = 8'd100; data2 = 8'd10;    // presented on the DONE cycle
    @(negedge clk);
    chk("b2b_done_drop", done, 0);
    chk("b2b_busy_rise", busy, 1);
    data1 = 8'd33; data2 = 8'd2;
    wait_done(n2);
    chk("b2b_spacing", n2 + 1, 9);
    chk("b2b_q2", quotient, 10);
    chk("b2b_r2", remainder, 0);
    $display("b2b op2 100 / 10 -> q=%0d r=%0d spacing=%0d", quotient, remainder, n2 + 1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a 77/3 operation
    do_op(8'd200, 8'd7, 1'b0);        // leave non-zero results held
    @(negedge clk);
    data1 = 8'd77; data2 = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", dbz, 0);
    $display("mid-run reset applied: q=%0d r=%0d busy=%0d", quotient, remainder, busy);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    do_op(8'd77, 8'd3, 1'b0);

    // Randomized operand pairs
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 8 == 0) ? 8'd0 : 8'($urandom);
      if (i % 50 == 1) ra = 8'd255;
      if (i % 50 == 2) ra = 8'd0;
      do_op(ra, rb, (i % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
